// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer-side and transmitter-side signals of the tx byte fifo
interface uart_tx_fifo_if #(parameter int ADDR_BITS = 4);
    logic [7:0] wr_data;
    logic wr_en;
    logic full;
    logic empty;
    logic [ADDR_BITS:0] count;
    logic overflow;
    logic clear_overflow;
    logic [7:0] tx_byte;
    logic tx_trigger;
    logic tx_ready;
    logic busy;
    modport master (
        output wr_data, wr_en, clear_overflow, tx_ready,
        input full, empty, count, overflow, tx_byte, tx_trigger, busy
    );
    modport slave (
        input wr_data, wr_en, clear_overflow, tx_ready,
        output full, empty, count, overflow, tx_byte, tx_trigger, busy
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte fifo that drains one byte per transmitter-ready handshake
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int ADDR_BITS = 4
) (
    input logic clock,
    input logic reset,
    uart_tx_fifo_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, FIRE = 2'd1, SETTLE = 2'd2;
    logic [7:0] mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic [ADDR_BITS:0] count;
    logic [1:0] state;
    logic [7:0] tx_byte;
    logic overflow, tx_trigger, full, empty, push, pop;
    always_comb begin
        full = count == (ADDR_BITS+1)'(DEPTH);
        empty = count == '0;
        push = bus.wr_en && !full;
        pop = state == IDLE && !empty && bus.tx_ready;
    end
    assign bus.full = full;
    assign bus.empty = empty;
    assign bus.count = count;
    assign bus.overflow = overflow;
    assign bus.tx_byte = tx_byte;
    assign bus.tx_trigger = tx_trigger;
    assign bus.busy = !empty || state != IDLE || !bus.tx_ready;
    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= bus.wr_data;
    // SETTLE gives the transmitter a cycle to drop ready before it is sampled again
    always_ff @(posedge clock)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
            tx_trigger <= 1'b0;
            tx_byte <= 8'h00;
            state <= IDLE;
        end else begin
            wr_ptr <= wr_ptr + ADDR_BITS'(push);
            rd_ptr <= rd_ptr + ADDR_BITS'(pop);
            count <= count + (ADDR_BITS+1)'(push) - (ADDR_BITS+1)'(pop);
            overflow <= (bus.wr_en && full) || (overflow && !bus.clear_overflow);
            tx_trigger <= pop;
            if (pop) tx_byte <= mem[rd_ptr];
            state <= pop ? FIRE : state == FIRE ? SETTLE : IDLE;
        end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized checks of the tx fifo, with a serial transmitter model
module tb_uart_tx_fifo;
    localparam int DEPTH = 16, AB = 4, CPB = 4;
    logic clock = 0, reset = 1;
    always #5 clock = ~clock;
    uart_tx_fifo_if #(.ADDR_BITS(AB)) bus ();
    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_BITS(AB)) dut (.clock(clock), .reset(reset), .bus(bus.slave));
    int total = 0, bad = 0;
    logic xmit_en = 0, manual_ready = 1, line = 1, tx_busy = 0;
    logic [9:0] frame;
    int bit_i = 0, tick = 0;
    assign bus.tx_ready = xmit_en ? !tx_busy : manual_ready;
    // transmitter model: start bit, 8 data bits LSB first, stop bit, CPB cycles each
    always @(posedge clock)
        if (!xmit_en) begin
            tx_busy <= 0;
            line <= 1;
        end else if (!tx_busy && bus.tx_trigger) begin
            frame <= {1'b1, bus.tx_byte, 1'b0};
            bit_i <= 0;
            tick <= 0;
            tx_busy <= 1;
            line <= 0;
        end else if (tx_busy) begin
            tick <= (tick == CPB - 1) ? 0 : tick + 1;
            if (tick == CPB - 1) begin
                if (bit_i == 9) begin
                    tx_busy <= 0;
                    line <= 1;
                end else begin
                    bit_i <= bit_i + 1;
                    line <= frame[bit_i + 1];
                end
            end
        end
    logic rx_act = 0;
    int rx_t = 0, rx_framing = 0, trig_cnt = 0, ready_viol = 0;
    logic [7:0] rx_sh;
    logic [7:0] rx_q[$];
    always @(negedge clock) begin
        if (bus.tx_trigger) begin
            trig_cnt++;
            if (xmit_en && tx_busy) ready_viol++;
        end
        if (!rx_act) begin
            if (xmit_en && line == 0) begin
                rx_act = 1;
                rx_t = 0;
            end
        end else begin
            rx_t++;
            if (rx_t >= 6 && (rx_t - 2) % CPB == 0) begin
                if ((rx_t - 2) / CPB <= 8) rx_sh[(rx_t - 2) / CPB - 1] = line;
                else begin
                    if (line) rx_q.push_back(rx_sh);
                    else rx_framing++;
                    rx_act = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) step();
        reset = 0;
        total += 7;
        if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
        if (bus.count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        if (bus.tx_trigger !== 1'b0) begin bad++; $display("FAIL reset_trigger: got %b want 0", bus.tx_trigger); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx_byte: got %h want 00", bus.tx_byte); end
    endtask

    task automatic test_single();
        int extra = 0;
        bus.wr_data = 8'hA5;
        bus.wr_en = 1;
        step();
        bus.wr_en = 0;
        total += 5;
        if (bus.count !== 5'd1) begin bad++; $display("FAIL single_count_after_write: got %0d want 1", bus.count); end
        if (bus.tx_trigger !== 1'b0) begin bad++; $display("FAIL single_trigger_early: got %b want 0", bus.tx_trigger); end
        step();
        if (bus.tx_trigger !== 1'b1) begin bad++; $display("FAIL single_trigger: got %b want 1", bus.tx_trigger); end
        if (bus.tx_byte !== 8'hA5) begin bad++; $display("FAIL single_tx_byte: got %h want a5", bus.tx_byte); end
        if (bus.count !== 5'd0) begin bad++; $display("FAIL single_count_after_pop: got %0d want 0", bus.count); end
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.tx_trigger) extra++;
        end
        total += 2;
        if (extra !== 0) begin bad++; $display("FAIL single_extra_triggers: got %0d want 0", extra); end
        if (bus.tx_byte !== 8'hA5) begin bad++; $display("FAIL single_tx_byte_hold: got %h want a5", bus.tx_byte); end
    endtask

    task automatic test_burst();
        logic [7:0] exp [3] = '{8'h11, 8'h22, 8'h33};
        int n = 0;
        xmit_en = 1;
        step();
        rx_q.delete();
        trig_cnt = 0;
        ready_viol = 0;
        rx_framing = 0;
        for (int i = 0; i < 3; i++) begin
            bus.wr_data = exp[i];
            bus.wr_en = 1;
            step();
        end
        bus.wr_en = 0;
        while (n < 600 && !(rx_q.size() == 3 && !bus.busy)) begin
            step();
            n++;
        end
        total += 5;
        if (n >= 600) begin bad++; $display("FAIL burst_timeout: got %0d bytes want 3", rx_q.size()); end
        if (rx_q.size() !== 3) begin bad++; $display("FAIL burst_rx_count: got %0d want 3", rx_q.size()); end
        for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== exp[i]) begin bad++; $display("FAIL burst_rx_byte%0d: got %h want %h", i, rx_q[i], exp[i]); end
        end
        if (trig_cnt !== 3) begin bad++; $display("FAIL burst_triggers: got %0d want 3", trig_cnt); end
        if (ready_viol !== 0) begin bad++; $display("FAIL burst_trigger_not_ready: got %0d want 0", ready_viol); end
        if (rx_framing !== 0) begin bad++; $display("FAIL burst_stop_bit: got %0d want 0", rx_framing); end
        xmit_en = 0;
        step();
    endtask

    task automatic test_overflow();
        logic [7:0] got[$];
        int n = 0;
        manual_ready = 0;
        for (int i = 0; i < 16; i++) begin
            bus.wr_data = 8'(i);
            bus.wr_en = 1;
            step();
        end
        total += 5;
        if (bus.full !== 1'b1) begin bad++; $display("FAIL ovf_full: got %b want 1", bus.full); end
        if (bus.count !== 5'd16) begin bad++; $display("FAIL ovf_count16: got %0d want 16", bus.count); end
        bus.wr_data = 8'hFF;
        step();
        bus.wr_en = 0;
        if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
        if (bus.count !== 5'd16) begin bad++; $display("FAIL ovf_count_after_drop: got %0d want 16", bus.count); end
        bus.clear_overflow = 1;
        step();
        bus.clear_overflow = 0;
        if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
        manual_ready = 1;
        while (n < 200 && got.size() < 16) begin
            step();
            if (bus.tx_trigger) got.push_back(bus.tx_byte);
            n++;
        end
        total++;
        if (got.size() !== 16) begin bad++; $display("FAIL ovf_drain_count: got %0d want 16", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            total++;
            if (got[i] !== 8'(i)) begin bad++; $display("FAIL ovf_drain_order%0d: got %h want %h", i, got[i], 8'(i)); end
        end
        repeat (4) step();
    endtask

    task automatic test_drop_pop();
        logic [7:0] vals[$];
        logic [7:0] got[$];
        int n = 0;
        manual_ready = 0;
        for (int i = 0; i < 16; i++) begin
            vals.push_back(8'($urandom_range(0, 8'hDF)));
            bus.wr_data = vals[i];
            bus.wr_en = 1;
            step();
        end
        manual_ready = 1;
        bus.wr_data = 8'hEE;
        step();
        bus.wr_en = 0;
        total += 4;
        if (bus.count !== 5'd15) begin bad++; $display("FAIL droppop_count: got %0d want 15", bus.count); end
        if (bus.overflow !== 1'b1) begin bad++; $display("FAIL droppop_overflow: got %b want 1", bus.overflow); end
        if (bus.tx_trigger !== 1'b1) begin bad++; $display("FAIL droppop_trigger: got %b want 1", bus.tx_trigger); end
        if (bus.tx_byte !== vals[0]) begin bad++; $display("FAIL droppop_byte: got %h want %h", bus.tx_byte, vals[0]); end
        got.push_back(bus.tx_byte);
        while (n < 200 && !(bus.empty && bus.tx_trigger == 0 && got.size() >= 16)) begin
            step();
            if (bus.tx_trigger) got.push_back(bus.tx_byte);
            n++;
        end
        total++;
        if (got.size() !== 16) begin bad++; $display("FAIL droppop_drain_count: got %0d want 16", got.size()); end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            total++;
            if (got[i] !== vals[i]) begin bad++; $display("FAIL droppop_order%0d: got %h want %h", i, got[i], vals[i]); end
        end
        bus.clear_overflow = 1;
        step();
        manual_ready = 0;
        bus.clear_overflow = 0;
        repeat (3) step();
        for (int i = 0; i < 16; i++) begin
            bus.wr_data = 8'($urandom);
            bus.wr_en = 1;
            step();
        end
        bus.clear_overflow = 1;
        step();
        bus.wr_en = 0;
        total++;
        if (bus.overflow !== 1'b1) begin bad++; $display("FAIL clear_vs_drop: got %b want 1", bus.overflow); end
        step();
        bus.clear_overflow = 0;
        manual_ready = 1;
        n = 0;
        while (n < 200 && bus.busy) begin
            step();
            n++;
        end
        total += 2;
        if (bus.overflow !== 1'b0) begin bad++; $display("FAIL clear_after: got %b want 0", bus.overflow); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL drain_idle: got busy %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int seen = 0, n = 0;
        manual_ready = 1;
        while (n < 50 && seen < 2) begin
            bus.wr_en = n < 5;
            bus.wr_data = 8'(8'h40 + n);
            step();
            if (bus.tx_trigger) seen++;
            n++;
        end
        bus.wr_en = 0;
        total++;
        if (seen !== 2) begin bad++; $display("FAIL mid_second_trigger: got %0d want 2", seen); end
        reset = 1;
        step();
        total += 3;
        if (bus.count !== 5'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", bus.count); end
        if (bus.empty !== 1'b1) begin bad++; $display("FAIL mid_empty: got %b want 1", bus.empty); end
        if (bus.tx_trigger !== 1'b0) begin bad++; $display("FAIL mid_trigger: got %b want 0", bus.tx_trigger); end
        reset = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.tx_trigger) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL mid_no_trigger: got %0d want 0", seen); end
    endtask

    task automatic test_random();
        logic [7:0] mq[$];
        logic [7:0] exp_byte = 8'h00;
        logic movf = 0, rdy, we, clr, pop_m, full_m;
        logic [7:0] wd;
        int since = 2;
        for (int i = 0; i < 600; i++) begin
            we = $urandom_range(0, 2) != 0;
            wd = 8'($urandom);
            clr = $urandom_range(0, 7) == 0;
            rdy = (i % 200) < 100 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
            bus.wr_en = we;
            bus.wr_data = wd;
            bus.clear_overflow = clr;
            manual_ready = rdy;
            full_m = mq.size() == DEPTH;
            pop_m = since >= 2 && mq.size() > 0 && rdy;
            if (pop_m) begin
                exp_byte = mq.pop_front();
                since = 0;
            end else if (since < 2) since++;
            if (we && !full_m) mq.push_back(wd);
            movf = (we && full_m) ? 1'b1 : clr ? 1'b0 : movf;
            step();
            total += 7;
            if (bus.count !== 5'(mq.size())) begin bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, bus.count, mq.size()); end
            if (bus.full !== (mq.size() == DEPTH)) begin bad++; $display("FAIL rnd_full@%0d: got %b", i, bus.full); end
            if (bus.empty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_empty@%0d: got %b", i, bus.empty); end
            if (bus.overflow !== movf) begin bad++; $display("FAIL rnd_overflow@%0d: got %b want %b", i, bus.overflow, movf); end
            if (bus.tx_trigger !== pop_m) begin bad++; $display("FAIL rnd_trigger@%0d: got %b want %b", i, bus.tx_trigger, pop_m); end
            if (bus.tx_byte !== exp_byte) begin bad++; $display("FAIL rnd_tx_byte@%0d: got %h want %h", i, bus.tx_byte, exp_byte); end
            if (bus.busy !== (mq.size() != 0 || since < 2 || !rdy)) begin bad++; $display("FAIL rnd_busy@%0d: got %b", i, bus.busy); end
        end
        bus.wr_en = 0;
        bus.clear_overflow = 0;
    endtask

    initial begin
        bus.wr_en = 0;
        bus.wr_data = 8'h00;
        bus.clear_overflow = 0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_drop_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
